run_step_controller: RTL and testbench

Run/single-step/breakpoint sequencer for the 8-bit processor core. It debounces the board's step and run push-buttons internally and issues the core's clock-enable: free-running in RUN, exactly one cycle per step press, and stopping on a breakpoint address or a halt request. It sits between the board pins and the core's `cpu_en` input, and reads the core's current `pc` back for breakpoint matching.

---
 rtl/run_step_controller_if.sv | 23 ++
 rtl/run_step_controller.sv | 136 +++++++++++++
 tb/tb_run_step_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/run_step_controller_if.sv
// Core-side bus of the run/step controller: program counter and breakpoint
// inputs in, clock-enable and status out.
interface run_step_controller_if #(
    parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] bp_addr;
  logic                bp_valid;
  logic                halt_req;
  logic                cpu_en;
  logic [1:0]          mode;
  logic [7:0]          step_count;

  modport master (
    input  pc, bp_addr, bp_valid, halt_req,
    output cpu_en, mode, step_count
  );

  modport slave (
    output pc, bp_addr, bp_valid, halt_req,
    input  cpu_en, mode, step_count
  );
endinterface

// File: rtl/run_step_controller.sv
// Run/single-step/breakpoint sequencer: debounces the step and run buttons and
// gates the core clock-enable in RUN, STEP, HALT and BREAK modes.
module run_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PC_WIDTH        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_pin,
  input  logic                    run_pin,
  run_step_controller_if.master   bus
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  logic [1:0] pins;
  logic [1:0] evt;
  logic       step_evt;
  logic       run_evt;

  assign pins     = {run_pin, step_pin};
  assign step_evt = evt[0];
  assign run_evt  = evt[1];

  // One debouncer per button; a press fires once, on release, after a full
  // DEBOUNCE_CYCLES run of low samples.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             armed_reg;
      logic             evt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          armed_reg <= 1'b0;
          evt_reg   <= 1'b0;
        end else begin
          evt_reg <= pins[gi] && armed_reg;
          if (!pins[gi]) begin
            if (cnt_reg == CNT_MAX)
              armed_reg <= 1'b1;
            else
              cnt_reg <= cnt_reg + CNT_W'(1);
          end else begin
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
          end
        end
      end

      assign evt[gi] = evt_reg;
    end
  endgenerate

  state_t              state_reg, state_next;
  logic                from_break_reg, from_break_next;
  logic                mask_reg, mask_next;
  logic [7:0]          step_count_reg;
  logic                cpu_en;
  logic                hit;
  logic [PC_WIDTH-1:0] pc_cur;

  assign pc_cur = bus.pc;
  assign hit    = bus.bp_valid && (pc_cur == bus.bp_addr) && !mask_reg;

  always_comb begin
    state_next      = state_reg;
    from_break_next = from_break_reg;
    cpu_en          = 1'b0;
    case (state_reg)
      S_HALT: begin
        if (step_evt) begin
          state_next      = S_STEP;
          from_break_next = 1'b0;
        end else if (run_evt) begin
          state_next = S_RUN;
        end
      end
      S_STEP: begin
        cpu_en     = 1'b1;
        state_next = from_break_reg ? S_BREAK : S_HALT;
      end
      S_RUN: begin
        // Gate combinationally so the breakpoint/HALT instruction never executes.
        cpu_en = !hit && !bus.halt_req;
        if (hit)
          state_next = S_BREAK;
        else if (bus.halt_req)
          state_next = S_HALT;
        else if (run_evt)
          state_next = S_HALT;
      end
      S_BREAK: begin
        if (step_evt) begin
          state_next      = S_STEP;
          from_break_next = 1'b1;
        end else if (run_evt) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_HALT;
    endcase
    // Suppress the breakpoint for the first RUN cycle so resuming at bp_addr moves on.
    mask_next = (state_next == S_RUN) && (state_reg != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_HALT;
      from_break_reg <= 1'b0;
      mask_reg       <= 1'b0;
      step_count_reg <= 8'd0;
    end else begin
      state_reg      <= state_next;
      from_break_reg <= from_break_next;
      mask_reg       <= mask_next;
      if (cpu_en)
        step_count_reg <= step_count_reg + 8'd1;
    end
  end

  assign bus.cpu_en     = cpu_en;
  assign bus.mode       = state_reg;
  assign bus.step_count = step_count_reg;

endmodule

// File: tb/tb_run_step_controller.sv
// Directed bench for run_step_controller with a 4-cycle debounce and a core
// model whose pc advances on every enabled cycle.
module tb_run_step_controller;
  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       step_pin = 1'b1;
  logic       run_pin  = 1'b1;
  logic [7:0] bp_addr  = 8'd0;
  logic       bp_valid = 1'b0;
  logic [7:0] halt_pc  = 8'd0;
  logic       halt_en  = 1'b0;
  logic [7:0] pc_model;
  int         checks   = 0;
  int         errors   = 0;
  int         n;
  logic       seen_en;

  run_step_controller_if #(.PC_WIDTH(8)) bus ();

  run_step_controller #(
    .DEBOUNCE_CYCLES(4),
    .PC_WIDTH       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .step_pin(step_pin),
    .run_pin (run_pin),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)
      pc_model <= 8'd0;
    else if (bus.cpu_en)
      pc_model <= pc_model + 8'd1;
  end

  assign bus.pc       = pc_model;
  assign bus.bp_addr  = bp_addr;
  assign bus.bp_valid = bp_valid;
  assign bus.halt_req = halt_en && (pc_model == halt_pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a button low for n_low samples, then release; returns just after the
  // release sample edge.
  task automatic press(input bit is_run, input int n_low);
    if (is_run) run_pin = 1'b0; else step_pin = 1'b0;
    repeat (n_low) tick();
    if (is_run) run_pin = 1'b1; else step_pin = 1'b1;
    tick();
    $display("press %s low=%0d mode=%0d pc=%0h count=%0d",
             is_run ? "run" : "step", n_low, bus.mode, pc_model, bus.step_count);
  endtask

  task automatic watch_idle(input int cycles);
    seen_en = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen_en = seen_en | bus.cpu_en;
      tick();
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset_mode", bus.mode, 2'b00);
    check("reset_en", bus.cpu_en, 1'b0);
    check("reset_count", bus.step_count, 8'd0);

    // Single step from HALT
    press(1'b0, 4);
    check("step_evt_cycle_mode", bus.mode, 2'b00);
    check("step_evt_cycle_en", bus.cpu_en, 1'b0);
    tick();
    check("step_mode", bus.mode, 2'b10);
    check("step_en", bus.cpu_en, 1'b1);
    tick();
    check("step_back_mode", bus.mode, 2'b00);
    check("step_back_en", bus.cpu_en, 1'b0);
    check("step_pc", pc_model, 8'd1);
    check("step_count1", bus.step_count, 8'd1);

    // Short press and glitch rejected
    press(1'b0, 3);
    watch_idle(4);
    check("short_press_en", seen_en, 1'b0);
    check("short_press_mode", bus.mode, 2'b00);
    press(1'b0, 1);
    watch_idle(4);
    check("glitch_en", seen_en, 1'b0);
    check("glitch_count", bus.step_count, 8'd1);

    // Run to breakpoint at 0x05 from pc 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bp_valid = 1'b1;
    bp_addr  = 8'h05;
    press(1'b1, 4);
    tick();
    check("run_mode", bus.mode, 2'b01);
    check("run_pc0", pc_model, 8'd0);
    n = 0;
    for (int i = 0; i < 20 && bus.cpu_en === 1'b1; i++) begin
      n++;
      tick();
    end
    check("bp_enable_cycles", n, 5);
    check("bp_pc", pc_model, 8'h05);
    check("bp_match_en", bus.cpu_en, 1'b0);
    check("bp_match_mode", bus.mode, 2'b01);
    check("bp_count", bus.step_count, 8'd5);
    tick();
    check("break_mode", bus.mode, 2'b11);
    $display("breakpoint pc=%0h count=%0d", pc_model, bus.step_count);

    // Resume from BREAK at 0x05, stop on halt_req at 0x09
    halt_pc = 8'h09;
    halt_en = 1'b1;
    press(1'b1, 4);
    check("break_hold_mode", bus.mode, 2'b11);
    tick();
    check("resume_mode", bus.mode, 2'b01);
    check("resume_no_rebreak", bus.cpu_en, 1'b1);
    tick();
    check("resume_pc6", pc_model, 8'h06);
    tick();
    tick();
    tick();
    check("halt_pc", pc_model, 8'h09);
    check("halt_en_low", bus.cpu_en, 1'b0);
    check("halt_mode_same", bus.mode, 2'b01);
    tick();
    check("halt_mode", bus.mode, 2'b00);
    check("halt_count", bus.step_count, 8'd9);

    // Step ignores halt_req
    press(1'b0, 4);
    tick();
    check("step_over_halt_en", bus.cpu_en, 1'b1);
    tick();
    check("step_over_halt_pc", pc_model, 8'h0A);
    check("step_over_halt_mode", bus.mode, 2'b00);
    halt_en = 1'b0;

    // Break at 0x0C, then step from BREAK returns to BREAK
    bp_addr = 8'h0C;
    press(1'b1, 4);
    tick();
    tick();
    tick();
    check("bp2_pc", pc_model, 8'h0C);
    tick();
    check("bp2_mode", bus.mode, 2'b11);
    press(1'b0, 4);
    tick();
    check("break_step_mode", bus.mode, 2'b10);
    check("break_step_en", bus.cpu_en, 1'b1);
    tick();
    check("break_step_ret", bus.mode, 2'b11);
    check("break_step_pc", pc_model, 8'h0D);
    check("break_step_count", bus.step_count, 8'd13);

    // Breakpoint and halt_req together: BREAK wins
    bp_addr = 8'h0F;
    halt_pc = 8'h0F;
    halt_en = 1'b1;
    press(1'b1, 4);
    tick();
    tick();
    tick();
    check("both_en", bus.cpu_en, 1'b0);
    tick();
    check("both_mode", bus.mode, 2'b11);
    check("both_pc", pc_model, 8'h0F);

    // Run button stops RUN after the evt cycle
    bp_valid = 1'b0;
    halt_en  = 1'b0;
    press(1'b1, 4);
    tick();
    check("run2_mode", bus.mode, 2'b01);
    press(1'b1, 4);
    check("stop_evt_en", bus.cpu_en, 1'b1);
    check("stop_evt_mode", bus.mode, 2'b01);
    tick();
    check("stop_mode", bus.mode, 2'b00);
    check("stop_en", bus.cpu_en, 1'b0);

    // step_count wrap, then reset in RUN with step held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    press(1'b1, 4);
    tick();
    for (int i = 0; i < 400 && bus.step_count !== 8'hFF; i++) tick();
    check("count_reach_ff", bus.step_count, 8'hFF);
    tick();
    check("count_wrap", bus.step_count, 8'h00);
    for (int i = 0; i < 400 && bus.step_count !== 8'hFC; i++) tick();
    check("count_reach_fc", bus.step_count, 8'hFC);
    step_pin = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_count", bus.step_count, 8'hFF);
    check("pre_reset_mode", bus.mode, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_run_mode", bus.mode, 2'b00);
    check("rst_run_en", bus.cpu_en, 1'b0);
    check("rst_run_count", bus.step_count, 8'd0);
    tick();
    tick();
    tick();
    step_pin = 1'b1;
    tick();
    watch_idle(3);
    check("held_reset_no_evt", seen_en, 1'b0);
    check("held_reset_mode", bus.mode, 2'b00);
    press(1'b0, 4);
    tick();
    check("after_reset_step", bus.mode, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
